pc_gen: RTL

Parametrised PC generator for the instruction fetch unit: holds the architectural fetch PC, selects the next PC from exception, ID-stage redirect (J-immediate, branch, JR) or sequential advance, and generalises sequential advance to FETCH_WIDTH instructions per fetch group. Unlike a purely combinational next-PC select, it owns the PC register. A redirect that arrives while the front end is stalled is captured and applied once the stall releases. Sits at the head of the IF stage, feeding the I-cache/fetch address path.

---
 rtl/gemini_ifu_pkg.sv | 16 +
 rtl/pc_next_sel.sv | 95 +++++++++
 rtl/pc_gen.sv | 115 +++++++++++
 3 files changed

// File: rtl/gemini_ifu_pkg.sv
// Shared IFU definitions: redirect-kind encodings, pc_gen FSM states and the default reset PC.
package gemini_ifu_pkg;

    localparam logic [1:0] RDR_J  = 2'd0;
    localparam logic [1:0] RDR_BR = 2'd1;
    localparam logic [1:0] RDR_JR = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        PEND_ID  = 2'd1,
        PEND_EXC = 2'd2
    } pc_gen_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for pc_gen: redirect target formation, priority mux and sequential advance.
// Optional `PC_GEN_GROUP_ALIGN_EN clips sequential advance at the aligned fetch-group boundary.
module pc_next_sel
    import gemini_ifu_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int CNT_W       = $clog2(FETCH_WIDTH + 1)
) (
    input  logic [31:0]      pc,
    input  pc_gen_state_e    state,
    input  logic [31:0]      pend_target,
    input  logic             stall,
    input  logic             exc_valid,
    input  logic [31:0]      exc_pc,
    input  logic             id_redirect_valid,
    input  logic [1:0]       id_redirect_kind,
    input  logic [31:0]      id_pc,
    input  logic [25:0]      id_j_imme,
    input  logic [31:0]      id_branch_target,
    input  logic [31:0]      id_rs_data,
    input  logic [CNT_W-1:0] inst_ok_cnt,
    output logic [31:0]      next_pc,
    output logic [31:0]      id_target,
    output logic             id_live,
    output logic             redirect_taken
);

    localparam logic [31:0] FW_32 = 32'(FETCH_WIDTH);

    logic [31:0] cnt_32;
    logic [31:0] advance;
    logic [31:0] seq_pc;
    logic        unused_id_pc_low;

    assign unused_id_pc_low = ^id_pc[27:0];

    always_comb begin
        id_target = '0;
        id_live   = id_redirect_valid;
        case (id_redirect_kind)
            RDR_J:   id_target = {id_pc[31:28], id_j_imme, 2'b00};
            RDR_BR:  id_target = id_branch_target;
            RDR_JR:  id_target = id_rs_data;
            default: id_live   = 1'b0;
        endcase
    end

    // Counts beyond the group size are clamped; the top asserts they never occur.
    always_comb begin
        cnt_32 = 32'(inst_ok_cnt);
        if (cnt_32 > FW_32) begin
            cnt_32 = FW_32;
        end
    end

`ifdef PC_GEN_GROUP_ALIGN_EN
    if ((FETCH_WIDTH & (FETCH_WIDTH - 1)) != 0) begin : g_fw_not_pow2
        $error("pc_next_sel: FETCH_WIDTH must be a power of two with group alignment");
    end

    logic [31:0] grp_ofs;
    logic [31:0] grp_room;

    always_comb begin
        grp_ofs  = {2'b00, pc[31:2]} & (FW_32 - 32'd1);
        grp_room = FW_32 - grp_ofs;
        advance  = (cnt_32 < grp_room) ? cnt_32 : grp_room;
    end
`else
    assign advance = cnt_32;
`endif

    assign seq_pc = pc + {advance[29:0], 2'b00};

    always_comb begin
        next_pc        = pc;
        redirect_taken = 1'b0;
        if (!stall) begin
            redirect_taken = 1'b1;
            if (state == PEND_EXC) begin
                next_pc = pend_target;
            end else if (exc_valid) begin
                next_pc = exc_pc;
            end else if (state == PEND_ID) begin
                next_pc = pend_target;
            end else if (id_live) begin
                next_pc = id_target;
            end else begin
                redirect_taken = 1'b0;
                next_pc        = seq_pc;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: owns the PC register and captures redirects that arrive during a stall.
// Optional `PC_GEN_GROUP_ALIGN_EN (see pc_next_sel) clips sequential advance at group boundaries.
module pc_gen
    import gemini_ifu_pkg::*;
#(
    parameter int          FETCH_WIDTH = 2,
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    localparam int         CNT_W       = $clog2(FETCH_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             exc_valid,
    input  logic [31:0]      exc_pc,
    input  logic             id_redirect_valid,
    input  logic [1:0]       id_redirect_kind,
    input  logic [31:0]      id_pc,
    input  logic [25:0]      id_j_imme,
    input  logic [31:0]      id_branch_target,
    input  logic [31:0]      id_rs_data,
    input  logic [CNT_W-1:0] inst_ok_cnt,
    output logic [31:0]      pc,
    output logic [31:0]      next_pc,
    output logic             redirect_pending,
    output logic             if_flush
);

    if (FETCH_WIDTH < 1) begin : g_bad_fetch_width
        $error("pc_gen: FETCH_WIDTH must be at least 1");
    end

    pc_gen_state_e state;
    logic [31:0]   pend_target;
    logic [31:0]   sel_next;
    logic [31:0]   id_target;
    logic          id_live;
    logic          redirect_taken;

    pc_next_sel #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .CNT_W       (CNT_W)
    ) u_next_sel (
        .pc               (pc),
        .state            (state),
        .pend_target      (pend_target),
        .stall            (stall),
        .exc_valid        (exc_valid),
        .exc_pc           (exc_pc),
        .id_redirect_valid(id_redirect_valid),
        .id_redirect_kind (id_redirect_kind),
        .id_pc            (id_pc),
        .id_j_imme        (id_j_imme),
        .id_branch_target (id_branch_target),
        .id_rs_data       (id_rs_data),
        .inst_ok_cnt      (inst_ok_cnt),
        .next_pc          (sel_next),
        .id_target        (id_target),
        .id_live          (id_live),
        .redirect_taken   (redirect_taken)
    );

    assign next_pc = rst ? RESET_PC : sel_next;

    // While stalled, an exception always wins the slot; ID redirects never displace a pending exception.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            pc               <= RESET_PC;
            pend_target      <= '0;
            redirect_pending <= 1'b0;
            if_flush         <= 1'b0;
        end else if (!stall) begin
            state            <= RUN;
            pc               <= sel_next;
            redirect_pending <= 1'b0;
            if_flush         <= redirect_taken;
        end else begin
            if_flush <= 1'b0;
            case (state)
                RUN: begin
                    if (exc_valid) begin
                        state            <= PEND_EXC;
                        pend_target      <= exc_pc;
                        redirect_pending <= 1'b1;
                    end else if (id_live) begin
                        state            <= PEND_ID;
                        pend_target      <= id_target;
                        redirect_pending <= 1'b1;
                    end
                end
                PEND_ID: begin
                    if (exc_valid) begin
                        state       <= PEND_EXC;
                        pend_target <= exc_pc;
                    end else if (id_live) begin
                        pend_target <= id_target;
                    end
                end
                PEND_EXC: begin
                    if (exc_valid) begin
                        pend_target <= exc_pc;
                    end
                end
                default: begin
                    state            <= RUN;
                    redirect_pending <= 1'b0;
                end
            endcase
        end
    end

    a_cnt_in_range: assert property (@(posedge clk) disable iff (rst)
        (!stall && !redirect_taken) |-> (32'(inst_ok_cnt) <= 32'(FETCH_WIDTH)));

endmodule
